// File: rtl/mc_bus_if.sv
// Host request/response and multiplexed memory-controller bus signals for mc_bus_master.
// master = initiator view, slave = host/memory-controller view.
interface mc_bus_if #(
  parameter int BUSWIDTH        = 16,
  parameter int DATAPAYLOADSIZE = 4
);
  logic                                req;
  logic                                req_rw;
  logic [15:0]                         req_addr;
  logic [BUSWIDTH*DATAPAYLOADSIZE-1:0] req_wdata;
  logic                                busy;
  logic                                done;
  logic [BUSWIDTH*DATAPAYLOADSIZE-1:0] rsp_rdata;
  logic                                AddrValid;
  logic                                rw;
  logic [BUSWIDTH-1:0]                 ad_out;
  logic                                ad_oe;
  logic [BUSWIDTH-1:0]                 ad_in;

  modport master (
    input  req, req_rw, req_addr, req_wdata, ad_in,
    output busy, done, rsp_rdata, AddrValid, rw, ad_out, ad_oe
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, ad_in,
    input  busy, done, rsp_rdata, AddrValid, rw, ad_out, ad_oe
  );
endinterface

// File: rtl/mc_bus_master.sv
// Processor-side initiator: one host request becomes an address phase followed by a
// DATAPAYLOADSIZE-word write or read burst on the multiplexed memory-controller bus.
module mc_bus_master #(
  parameter int BUSWIDTH        = 16,
  parameter int DATAPAYLOADSIZE = 4,
  parameter int RD_LAT          = 2
) (
  input logic      clk,
  input logic      resetH,
  mc_bus_if.master bus
);
  localparam int CW = (DATAPAYLOADSIZE > 1) ? $clog2(DATAPAYLOADSIZE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATAPAYLOADSIZE - 1);
  localparam logic [1:0]    WAIT_LAST = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          wait_q, wait_d;
  logic                rw_q, rw_d;
  logic [15:0]         addr_q, addr_d;
  logic [BUSWIDTH-1:0] wword_q  [DATAPAYLOADSIZE];
  logic [BUSWIDTH-1:0] wword_d  [DATAPAYLOADSIZE];
  logic [BUSWIDTH-1:0] shadow_q [DATAPAYLOADSIZE];
  logic [BUSWIDTH-1:0] shadow_d [DATAPAYLOADSIZE];
  logic [BUSWIDTH-1:0] rdata_q  [DATAPAYLOADSIZE];
  logic [BUSWIDTH-1:0] rdata_d  [DATAPAYLOADSIZE];

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wword_q  <= '{default: '0};
      shadow_q <= '{default: '0};
      rdata_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wword_q  <= wword_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wword_d  = wword_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = ADDR;
          rw_d    = bus.req_rw;
          addr_d  = bus.req_addr;
          for (int unsigned i = 0; i < DATAPAYLOADSIZE; i++) begin
            wword_d[i] = bus.req_wdata[i*BUSWIDTH +: BUSWIDTH];
          end
          cnt_d  = '0;
          wait_d = '0;
        end
      end
      ADDR: begin
        cnt_d  = '0;
        wait_d = '0;
        if (!rw_q)           state_d = WDATA;
        else if (RD_LAT > 1) state_d = RWAIT;
        else                 state_d = RDATA;
      end
      WDATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RWAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = RDATA;
          cnt_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RDATA: begin
        shadow_d[cnt_q] = bus.ad_in;
        // The last word bypasses the shadow so rsp_rdata is complete when DONE starts.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          rdata_d = shadow_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.AddrValid = (state_q == ADDR);
    bus.ad_oe     = (state_q == ADDR) || (state_q == WDATA);
    bus.rw        = 1'b0;
    bus.ad_out    = '0;
    case (state_q)
      ADDR: begin
        bus.rw     = rw_q;
        bus.ad_out = BUSWIDTH'(addr_q);
      end
      WDATA:        bus.ad_out = wword_q[cnt_q];
      RWAIT, RDATA: bus.rw     = 1'b1;
      default:      bus.rw     = 1'b0;
    endcase
    for (int unsigned i = 0; i < DATAPAYLOADSIZE; i++) begin
      bus.rsp_rdata[i*BUSWIDTH +: BUSWIDTH] = rdata_q[i];
    end
  end
endmodule
